// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_pkg
// Purpose  : Shared encodings for the load/store engine. Defines the func3
//            size/sign codes (MEM_MODE_*), the FSM state codes (MEM_STATE_*)
//            and small request-decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

  localparam logic [2:0] MEM_MODE_B  = 3'b000;
  localparam logic [2:0] MEM_MODE_H  = 3'b001;
  localparam logic [2:0] MEM_MODE_W  = 3'b010;
  localparam logic [2:0] MEM_MODE_BU = 3'b100;
  localparam logic [2:0] MEM_MODE_HU = 3'b101;

  localparam logic [2:0] MEM_STATE_IDLE = 3'd0;
  localparam logic [2:0] MEM_STATE_REQ0 = 3'd1;
  localparam logic [2:0] MEM_STATE_RSP0 = 3'd2;
  localparam logic [2:0] MEM_STATE_REQ1 = 3'd3;
  localparam logic [2:0] MEM_STATE_RSP1 = 3'd4;
  localparam logic [2:0] MEM_STATE_DONE = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = MEM_STATE_IDLE,
    ST_REQ0 = MEM_STATE_REQ0,
    ST_RSP0 = MEM_STATE_RSP0,
    ST_REQ1 = MEM_STATE_REQ1,
    ST_RSP1 = MEM_STATE_RSP1,
    ST_DONE = MEM_STATE_DONE
  } state_e;

  // Byte-lane mask of an access before it is shifted to its offset.
  function automatic logic [3:0] f_size_mask(input logic [2:0] mode);
    case (mode)
      MEM_MODE_B, MEM_MODE_BU: f_size_mask = 4'b0001;
      MEM_MODE_H, MEM_MODE_HU: f_size_mask = 4'b0011;
      MEM_MODE_W:              f_size_mask = 4'b1111;
      default:                 f_size_mask = 4'b0000;
    endcase
  endfunction

  // Undefined func3 codes, and unsigned variants used with a store.
  function automatic logic f_mode_illegal(input logic [2:0] mode, input logic we);
    case (mode)
      3'b011, 3'b110, 3'b111:  f_mode_illegal = 1'b1;
      MEM_MODE_BU, MEM_MODE_HU: f_mode_illegal = we;
      default:                 f_mode_illegal = 1'b0;
    endcase
  endfunction

  // Expand a 4-bit byte enable into a 32-bit data mask.
  function automatic logic [31:0] f_lane_mask(input logic [3:0] be);
    f_lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_formatter.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit_load_formatter
// Purpose  : Combinational load result formatting. Bytes are taken little-
//            endian starting at lane 'offset' of word0 and continuing into
//            word1, right-aligned, then sign- or zero-extended by mode.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit_load_formatter
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word0_i,
  input  logic [31:0] word1_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  mode_i,
  output logic [31:0] read_data_o
);

  logic [63:0] shifted;
  logic        unused_bits;

  assign shifted     = {word1_i, word0_i} >> {offset_i, 3'b000};
  assign unused_bits = ^shifted[63:32];

  // Extend the right-aligned bytes according to the access size and sign.
  always_comb begin
    read_data_o = '0;
    case (mode_i)
      MEM_MODE_B:  read_data_o = {{24{shifted[7]}}, shifted[7:0]};
      MEM_MODE_H:  read_data_o = {{16{shifted[15]}}, shifted[15:0]};
      MEM_MODE_W:  read_data_o = shifted[31:0];
      MEM_MODE_BU: read_data_o = {24'h0, shifted[7:0]};
      MEM_MODE_HU: read_data_o = {16'h0, shifted[15:0]};
      default:     read_data_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Multi-cycle RISC-V load/store engine in front of a single-port
//            synchronous word SRAM. Converts byte-addressed B/H/W requests
//            into word accesses with byte enables and formats load results.
//            Optional macro MISALIGNED_SPLIT_EN: accept misaligned accesses,
//            splitting word-crossing ones into two SRAM accesses. Without it
//            every misaligned request is rejected.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       address,
  input  logic [2:0]        mode,
  input  logic              write_enable,
  input  logic [31:0]       write_data,
  output logic              done,
  output logic [31:0]       read_data,
  output logic              active,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W+1:0] addr_q;
  logic [2:0]        mode_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       read_data_q;

  logic [7:0]        req_win;
  logic              req_reject;
  logic [7:0]        be_win;
  logic [63:0]       data_win;
  logic [ADDR_W-1:0] word0_addr;
  logic [31:0]       fmt_word0;
  logic [31:0]       fmt_data;
  logic              unused_bits;

  // Lane window of the incoming request: bits [7:4] are lanes of word1.
  assign req_win = {4'b0000, f_size_mask(mode)} << address[1:0];

`ifdef MISALIGNED_SPLIT_EN
  logic              cross_q;
  logic [31:0]       word0_q;
  logic              req_cross;
  logic [ADDR_W-1:0] word1_addr;

  assign req_cross   = |req_win[7:4];
  assign req_reject  = f_mode_illegal(mode, write_enable);
  assign word1_addr  = word0_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign fmt_word0   = (state_q == ST_RSP1) ? word0_q : mem_rdata;
  assign unused_bits = ^address[31:ADDR_W+2];
`else
  logic req_misal;

  assign req_misal   = ((mode[1:0] == 2'b01) && address[0]) ||
                       ((mode == MEM_MODE_W) && (address[1:0] != 2'b00));
  assign req_reject  = f_mode_illegal(mode, write_enable) || req_misal;
  assign fmt_word0   = mem_rdata;
  assign unused_bits = ^{address[31:ADDR_W+2], be_win[7:4], data_win[63:32]};
`endif

  // Lane-shifted enables and data of the latched store.
  assign be_win     = {4'b0000, f_size_mask(mode_q)} << addr_q[1:0];
  assign data_win   = {32'h0, wdata_q} << {addr_q[1:0], 3'b000};
  assign word0_addr = addr_q[ADDR_W+1:2];

  mem_access_unit_load_formatter u_fmt (
    .word0_i     (fmt_word0),
    .word1_i     (mem_rdata),
    .offset_i    (addr_q[1:0]),
    .mode_i      (mode_q),
    .read_data_o (fmt_data)
  );

  assign done      = (state_q == ST_DONE);
  assign err       = done && err_q;
  assign read_data = read_data_q;
  assign active    = ((state_q == ST_IDLE) && start) ||
                     (state_q inside {ST_REQ0, ST_RSP0, ST_REQ1, ST_RSP1});

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = req_reject ? ST_DONE : ST_REQ0;
      ST_REQ0: state_d = ST_RSP0;
`ifdef MISALIGNED_SPLIT_EN
      ST_RSP0: state_d = cross_q ? ST_REQ1 : ST_DONE;
      ST_REQ1: state_d = ST_RSP1;
      ST_RSP1: state_d = ST_DONE;
`else
      ST_RSP0: state_d = ST_DONE;
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // SRAM strobes; store enables/data only on write cycles.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_REQ0: begin
        mem_en   = 1'b1;
        mem_we   = we_q;
        mem_addr = word0_addr;
        if (we_q) begin
          mem_be    = be_win[3:0];
          mem_wdata = data_win[31:0] & f_lane_mask(be_win[3:0]);
        end
      end
`ifdef MISALIGNED_SPLIT_EN
      ST_REQ1: begin
        mem_en   = 1'b1;
        mem_we   = we_q;
        mem_addr = word1_addr;
        if (we_q) begin
          mem_be    = be_win[7:4];
          mem_wdata = data_win[63:32] & f_lane_mask(be_win[7:4]);
        end
      end
`endif
      default: ;
    endcase
  end

  // Request latch and load result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= '0;
      mode_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      read_data_q <= '0;
`ifdef MISALIGNED_SPLIT_EN
      cross_q     <= 1'b0;
      word0_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            addr_q  <= address[ADDR_W+1:0];
            mode_q  <= mode;
            we_q    <= write_enable;
            wdata_q <= write_data;
            err_q   <= req_reject;
`ifdef MISALIGNED_SPLIT_EN
            cross_q <= req_cross;
`endif
            if (req_reject) read_data_q <= '0;
          end
        end
        ST_RSP0: begin
`ifdef MISALIGNED_SPLIT_EN
          word0_q <= mem_rdata;
          if (!cross_q) read_data_q <= we_q ? 32'h0 : fmt_data;
`else
          read_data_q <= we_q ? 32'h0 : fmt_data;
`endif
        end
`ifdef MISALIGNED_SPLIT_EN
        ST_RSP1: read_data_q <= we_q ? 32'h0 : fmt_data;
`endif
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Scoreboard bench for mem_access_unit with a behavioural SRAM.
//            Honours MISALIGNED_SPLIT_EN for the misaligned vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int ADDR_W = 12;
  localparam logic [2:0] M_B = 3'b000, M_H = 3'b001, M_W = 3'b010,
                         M_BU = 3'b100, M_HU = 3'b101;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, write_enable = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic [2:0]  mode = '0;
  logic done, active, err, mem_en, mem_we;
  logic [31:0] read_data, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic load_mem = 1'b0;

  typedef struct {
    logic [31:0] rd; logic chk_rd; logic err; int lat; int nen;
    logic [ADDR_W-1:0] a0; logic chk_wd; logic [3:0] be0; logic [31:0] wd0; int scyc;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int total = 0, bad = 0, cyc = 0, done_cnt = 0, nen = 0, tgt;
  logic [ADDR_W-1:0] a0_s;
  logic [3:0]  be0_s;
  logic [31:0] wd0_s;
  logic [31:0] sram [0:(1<<ADDR_W)-1];

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .address(address), .mode(mode),
    .write_enable(write_enable), .write_data(write_data), .done(done),
    .read_data(read_data), .active(active), .err(err), .mem_en(mem_en),
    .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port SRAM, one-cycle read latency.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < (1 << ADDR_W); i++) sram[i] <= 32'h0;
      sram[4]    <= 32'h8899AABB;
      sram[5]    <= 32'h11223344;
      sram[4095] <= 32'hA5000000;
      sram[0]    <= 32'h0000007F;
    end else if (mem_en) begin
      mem_rdata <= sram[mem_addr];
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(logic [31:0] rd, logic chk_rd, logic er, int lat, int n,
                              logic [ADDR_W-1:0] a0, logic chk_wd, logic [3:0] be0,
                              logic [31:0] wd0);
    exp_t x;
    x.rd = rd; x.chk_rd = chk_rd; x.err = er; x.lat = lat; x.nen = n; x.a0 = a0;
    x.chk_wd = chk_wd; x.be0 = be0; x.wd0 = wd0; x.scyc = 0;
    return x;
  endfunction

  function automatic exp_t ld(logic [31:0] rd, logic [ADDR_W-1:0] a0);
    return mk(rd, 1'b1, 1'b0, 3, 1, a0, 1'b0, 4'h0, 32'h0);
  endfunction
  function automatic exp_t ld2(logic [31:0] rd, logic [ADDR_W-1:0] a0);
    return mk(rd, 1'b1, 1'b0, 5, 2, a0, 1'b0, 4'h0, 32'h0);
  endfunction
  function automatic exp_t rej();
    return mk(32'h0, 1'b1, 1'b1, 1, 0, '0, 1'b0, 4'h0, 32'h0);
  endfunction
  function automatic exp_t st(logic [ADDR_W-1:0] a0, logic [3:0] be, logic [31:0] wd, int lat, int n);
    return mk(32'h0, 1'b0, 1'b0, lat, n, a0, 1'b1, be, wd);
  endfunction

  // Monitor: records SRAM strobes and scores every done pulse.
  always @(negedge clk) begin
    if (!rst) nen = 0;
    else begin
      if (mem_en) begin
        if (nen == 0) begin a0_s = mem_addr; be0_s = mem_be; wd0_s = mem_wdata; end
        nen++;
      end
      if (done) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done=1 expected no pending request");
        end else begin
          e = sbq.pop_front();
          check("latency", cyc - e.scyc, e.lat);
          check("err", {31'h0, err}, {31'h0, e.err});
          check("active_in_done", {31'h0, active}, 32'h0);
          check("mem_en_count", nen, e.nen);
          if (e.chk_rd) check("read_data", read_data, e.rd);
          if (e.nen > 0 && nen > 0) check("mem_addr", {20'h0, a0_s}, {20'h0, e.a0});
          if (e.chk_wd) begin
            check("mem_be", {28'h0, be0_s}, {28'h0, e.be0});
            check("mem_wdata", wd0_s, e.wd0);
          end
        end
        nen = 0;
        done_cnt++;
      end
    end
  end

  task automatic wait_done(input int t);
    for (int i = 0; i < 12; i++) begin
      if (done_cnt >= t) return;
      @(negedge clk); #2;
    end
    total++; bad++;
    $display("FAIL timeout: got done_cnt=%0d expected %0d", done_cnt, t);
    sbq.delete();
  endtask

  task automatic run_op(input logic [31:0] a, input logic [2:0] m, input logic w,
                        input logic [31:0] wd, input exp_t x);
    exp_t y;
    int   t;
    y = x;
    @(negedge clk);
    address = a; mode = m; write_enable = w; write_data = wd; start = 1'b1;
    y.scyc = cyc; sbq.push_back(y); t = done_cnt + 1;
    #1 check("active_start", {31'h0, active}, 32'h1);
    @(negedge clk); start = 1'b0;
    wait_done(t);
  endtask

  initial begin
    load_mem = 1'b1;
    repeat (2) @(negedge clk);
    load_mem = 1'b0;
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_active", {31'h0, active}, 32'h0);
    check("rst_mem_en", {31'h0, mem_en}, 32'h0);
    check("rst_mem_we", {31'h0, mem_we}, 32'h0);
    check("rst_mem_be", {28'h0, mem_be}, 32'h0);
    check("rst_mem_addr", {20'h0, mem_addr}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_read_data", read_data, 32'h0);
    rst = 1'b1;

    run_op(32'h10, M_W,  1'b0, 32'h0, ld(32'h8899AABB, 4));
    run_op(32'h13, M_B,  1'b0, 32'h0, ld(32'hFFFFFF88, 4));
    run_op(32'h13, M_BU, 1'b0, 32'h0, ld(32'h00000088, 4));
    run_op(32'h10, M_H,  1'b0, 32'h0, ld(32'hFFFFAABB, 4));
    run_op(32'h16, M_HU, 1'b0, 32'h0, ld(32'h00001122, 5));
    run_op(32'h17, M_B,  1'b0, 32'h0, ld(32'h00000011, 5));
`ifdef MISALIGNED_SPLIT_EN
    run_op(32'h13,   M_W, 1'b0, 32'h0, ld2(32'h22334488, 4));
    run_op(32'h11,   M_H, 1'b0, 32'h0, ld(32'hFFFF99AA, 4));
    run_op(32'h3FFF, M_H, 1'b0, 32'h0, ld2(32'h00007FA5, 12'hFFF));
`else
    run_op(32'h13,   M_W, 1'b0, 32'h0, rej());
    run_op(32'h11,   M_H, 1'b0, 32'h0, rej());
    run_op(32'h3FFF, M_H, 1'b0, 32'h0, rej());
`endif
    run_op(32'h12, M_H,  1'b1, 32'h0000CAFE, st(4, 4'b1100, 32'hCAFE0000, 3, 1));
    run_op(32'h10, M_W,  1'b0, 32'h0, ld(32'hCAFEAABB, 4));
    run_op(32'h15, M_B,  1'b1, 32'h000000EE, st(5, 4'b0010, 32'h0000EE00, 3, 1));
    run_op(32'h15, M_BU, 1'b0, 32'h0, ld(32'h000000EE, 5));
    run_op(32'h15, M_B,  1'b0, 32'h0, ld(32'hFFFFFFEE, 5));

    // A start pulse during RSP0 must be ignored.
    @(negedge clk);
    address = 32'h14; mode = M_W; write_enable = 1'b0; start = 1'b1;
    e = ld(32'h1122EE44, 5); e.scyc = cyc; sbq.push_back(e); tgt = done_cnt + 1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); address = 32'h13; mode = M_B; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(tgt);
    repeat (6) @(negedge clk);
    check("single_done", done_cnt, tgt);

    run_op(32'h10, 3'b011, 1'b0, 32'h0, rej());
    run_op(32'h10, 3'b111, 1'b0, 32'h0, rej());
    run_op(32'h10, M_BU,   1'b1, 32'h000000FF, rej());
    run_op(32'h10, M_HU,   1'b1, 32'h0000FFFF, rej());

    // Reset in the middle of an access.
    @(negedge clk);
    write_enable = 1'b1; mode = M_W; start = 1'b1;
`ifdef MISALIGNED_SPLIT_EN
    address = 32'h11; write_data = 32'hDDCCBBAA;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("req1_mem_en", {31'h0, mem_en}, 32'h1);
    check("req1_mem_addr", {20'h0, mem_addr}, 32'h5);
    check("req1_mem_be", {28'h0, mem_be}, 32'h1);
    check("req1_mem_wdata", mem_wdata, 32'h000000DD);
`else
    address = 32'h14; write_data = 32'hDEADBEEF;
    @(negedge clk); start = 1'b0;
    check("req0_mem_en", {31'h0, mem_en}, 32'h1);
`endif
    rst = 1'b0;
    #1;
    check("midrst_mem_en", {31'h0, mem_en}, 32'h0);
    check("midrst_active", {31'h0, active}, 32'h0);
    repeat (2) @(negedge clk);
    check("midrst_read_data", read_data, 32'h0);
    rst = 1'b1;
`ifdef MISALIGNED_SPLIT_EN
    run_op(32'h10, M_W, 1'b0, 32'h0, ld(32'hCCBBAABB, 4));
`else
    run_op(32'h10, M_W, 1'b0, 32'h0, ld(32'hCAFEAABB, 4));
`endif
    run_op(32'h14, M_W, 1'b0, 32'h0, ld(32'h1122EE44, 5));

`ifdef MISALIGNED_SPLIT_EN
    run_op(32'h17, M_H, 1'b1, 32'h0000BEEF, st(5, 4'b1000, 32'hEF000000, 5, 2));
    run_op(32'h17, M_H, 1'b0, 32'h0, ld2(32'hFFFFBEEF, 5));
    run_op(32'h18, M_B, 1'b0, 32'h0, ld(32'hFFFFFFBE, 6));
`else
    run_op(32'h17, M_H, 1'b1, 32'h0000BEEF, rej());
    run_op(32'h12, M_W, 1'b0, 32'h0, rej());
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Multi-cycle load/store engine sitting directly downstream of the CPU's memory-stage request (start/address/mode/write_enable/write_data) and upstream of a single-port synchronous word SRAM.
- Converts byte-addressed RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses with byte enables, then sign/zero-extends read results.
- Reports `active` so the stage counter stalls, and pulses `done` with the result.

Parameters:
- ADDR_W, 12, SRAM word-address width (2^ADDR_W 32-bit words).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only in IDLE
- address  in  32  byte address
- mode  in  3  func3 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- write_enable  in  1  1 = store, 0 = load
- write_data  in  32  store data, right-aligned
- done  out  1  one-cycle completion pulse
- read_data  out  32  formatted load result; valid while done=1, held until next done
- active  out  1  busy/stall indication to the stage counter
- err  out  1  request rejected; valid with done
- mem_en  out  1  SRAM access strobe
- mem_we  out  1  SRAM write
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_addr  out  ADDR_W  SRAM word address
- mem_wdata  out  32  lane-aligned store data
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_en

Behaviour:
- Reset: state=IDLE; done, err, active, mem_en, mem_we=0; mem_be=0; mem_addr, mem_wdata, read_data=0.
- Reset asserted mid-operation forces IDLE immediately, asynchronously: mem_en drops the same instant and the pending access is abandoned. A word already strobed stays written.
- FSM states: IDLE, REQ0, RSP0, REQ1, RSP1, DONE.
- IDLE & start:
  - Latch address, mode, write_enable and write_data.
  - Go to REQ0, or to DONE with err=1 if rejected.
- REQ0: mem_en=1, mem_addr=address[ADDR_W+1:2]. If a store: mem_we=1 with lane-shifted data/enables.
- RSP0: loads capture mem_rdata.
  - Access crosses a word boundary → REQ1.
  - Otherwise → DONE.
- REQ1: mem_addr = word0+1, wrapping modulo 2^ADDR_W. RSP1 captures the second word, then → DONE.
- DONE: done=1 for exactly one cycle, then → IDLE.
- Latency, counting the start cycle as 0:
  - aligned or in-word access: done at cycle 3
  - split access: done at cycle 5
  - rejected request: done at cycle 1
- active = (IDLE & start) | state∈{REQ0,RSP0,REQ1,RSP1}. Combinational, so the CPU stalls in the start cycle. active is low in DONE.
- start while not IDLE is ignored.
- Rejected requests (err=1), no SRAM access, read_data=0:
  - mode ∈ {011,110,111}
  - store with mode 100 or 101
- Misaligned:
  - H/HU/SH with address[0]=1
  - W/SW with address[1:0]≠0
  - Crossing subset: H at offset 3, W at offset 1/2/3.
- Load formatting:
  - Bytes are assembled little-endian from word0 (upper lanes) then word1 (lower lanes).
  - Result is right-aligned.
  - B/H are sign-extended; BU/HU are zero-extended.
- Store lanes: byte k of write_data goes to lane (address[1:0]+k) mod 4. Lanes falling in word1 are written in REQ1.

Optional Feature:
- MISALIGNED_SPLIT_EN defined:
  - Misaligned in-word accesses use one access.
  - Crossing accesses split into two as above.
- MISALIGNED_SPLIT_EN undefined:
  - Every misaligned request is rejected (err=1, done at cycle 1, no mem_en).
  - REQ1/RSP1 are not synthesised.

Decomposition:
- Shared defines file (arch_defines.v): MEM_MODE_* func3 encodings and MEM_STATE_* FSM encodings.
- One natural sub-module, load_formatter (combinational): {word1, word0, offset, mode} → read_data.

Test Plan:
- SRAM word 4 = 0x8899AABB, word 5 = 0x11223344. LW 0x10 → mem_en cycle 1 with mem_addr=4; done cycle 3; read_data=0x8899AABB; err=0.
- LB 0x13 → 0xFFFFFF88. LBU 0x13 → 0x00000088. LH 0x10 → 0xFFFFAABB.
- SH 0x12 with write_data=0x0000CAFE → mem_be=1100, mem_wdata=0xCAFE0000. Following LW 0x10 → 0xCAFEAABB.
- LW 0x13:
  - With MISALIGNED_SPLIT_EN: reads words 4 then 5; done cycle 5; read_data=0x22334488.
  - Without it: err=1, done cycle 1, mem_en never asserted.
- Split SW 0x11 with rst low during REQ1 → mem_en falls immediately, active=0. Only word 4 lanes 1–3 are modified.
- start pulsed during RSP0 → ignored, exactly one done. mode=011 → err=1, read_data=0, no SRAM access.
